// File: rtl/ternary_alu_rr_scheduler.sv
// Round-robin front end for one shared, fixed-latency ternary ALU: picks one requester per
// cycle, registers the issue, and carries the requester ID alongside the ALU pipeline.
module ternary_alu_rr_scheduler #(
   parameter  int NUM_REQ     = 4,
   parameter  int ALU_LATENCY = 2,
   localparam int IDW         = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*16-1:0]  req_a_bin,
   input  logic [NUM_REQ*16-1:0]  req_b_bin,
   input  logic [NUM_REQ*3-1:0]   req_op,
   input  logic                   hold,
   output logic                   alu_valid_in,
   output logic [15:0]            alu_a_bin,
   output logic [15:0]            alu_b_bin,
   output logic [2:0]             alu_op,
   input  logic                   alu_valid_out,
   input  logic [15:0]            alu_result_bin,
   input  logic [1:0]             alu_carry_bin,
   input  logic                   alu_zero_flag,
   input  logic                   alu_neg_flag,
   output logic                   rsp_valid,
   output logic [IDW-1:0]         rsp_id,
   output logic [15:0]            rsp_result_bin,
   output logic [1:0]             rsp_carry_bin,
   output logic                   rsp_zero_flag,
   output logic                   rsp_neg_flag,
   output logic                   sync_err
);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] issue_id;
   logic           gnt_any;
   logic           accept;
   logic           tag_vld;
   logic [IDW-1:0] tag_id;
   int             idx;

   // Search starts one past the last winner so the previous grantee has lowest priority.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (gnt_any && !hold && !rst) req_ready[gnt_id] = 1'b1;
   end

   assign accept = |(req_valid & req_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= IDW'(NUM_REQ - 1);
         alu_valid_in <= 1'b0;
         alu_a_bin    <= '0;
         alu_b_bin    <= '0;
         alu_op       <= '0;
         issue_id     <= '0;
      end else if (accept) begin
         rr_ptr       <= gnt_id;
         alu_valid_in <= 1'b1;
         alu_a_bin    <= req_a_bin[gnt_id*16 +: 16];
         alu_b_bin    <= req_b_bin[gnt_id*16 +: 16];
         alu_op       <= req_op[gnt_id*3 +: 3];
         issue_id     <= gnt_id;
      end else begin
         alu_valid_in <= 1'b0;
      end
   end

   // Tag pipe mirrors the ALU depth exactly; it never stalls because the ALU never does.
   generate
      if (ALU_LATENCY == 0) begin : gen_tag_comb
         assign tag_vld = alu_valid_in;
         assign tag_id  = issue_id;
      end else begin : gen_tag_pipe
         logic [ALU_LATENCY-1:0]          vld_pipe;
         logic [ALU_LATENCY-1:0][IDW-1:0] id_pipe;
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_pipe <= '0;
               id_pipe  <= '0;
            end else begin
               vld_pipe[0] <= alu_valid_in;
               id_pipe[0]  <= issue_id;
               for (int s = 1; s < ALU_LATENCY; s++) begin
                  vld_pipe[s] <= vld_pipe[s-1];
                  id_pipe[s]  <= id_pipe[s-1];
               end
            end
         end
         assign tag_vld = vld_pipe[ALU_LATENCY-1];
         assign tag_id  = id_pipe[ALU_LATENCY-1];
      end
   endgenerate

   assign rsp_valid      = tag_vld & alu_valid_out & !rst;
   assign rsp_id         = tag_id;
   assign rsp_result_bin = alu_result_bin;
   assign rsp_carry_bin  = alu_carry_bin;
   assign rsp_zero_flag  = alu_zero_flag;
   assign rsp_neg_flag   = alu_neg_flag;

   // Sticky: any disagreement means the ID routing can no longer be trusted.
   always_ff @(posedge clk) begin
      if (rst)                          sync_err <= 1'b0;
      else if (tag_vld != alu_valid_out) sync_err <= 1'b1;
   end

endmodule

// File: tb/tb_ternary_alu_rr_scheduler.sv
// Directed + random bench: a behavioural round-robin/queue model predicts grants, issue and
// tagged responses; a toy 2-stage ALU closes the loop and can drop or force valids.
module tb_ternary_alu_rr_scheduler;
   localparam int N = 4;
   localparam int L = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*16-1:0] req_a_bin, req_b_bin;
   logic [N*3-1:0]  req_op;
   logic            hold;
   logic            alu_valid_in;
   logic [15:0]     alu_a_bin, alu_b_bin;
   logic [2:0]      alu_op;
   logic            alu_valid_out;
   logic [15:0]     alu_result_bin;
   logic [1:0]      alu_carry_bin;
   logic            alu_zero_flag, alu_neg_flag;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [15:0]     rsp_result_bin;
   logic [1:0]      rsp_carry_bin;
   logic            rsp_zero_flag, rsp_neg_flag;
   logic            sync_err;

   ternary_alu_rr_scheduler #(.NUM_REQ(N), .ALU_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a_bin(req_a_bin), .req_b_bin(req_b_bin), .req_op(req_op), .hold(hold),
      .alu_valid_in(alu_valid_in), .alu_a_bin(alu_a_bin), .alu_b_bin(alu_b_bin),
      .alu_op(alu_op), .alu_valid_out(alu_valid_out), .alu_result_bin(alu_result_bin),
      .alu_carry_bin(alu_carry_bin), .alu_zero_flag(alu_zero_flag),
      .alu_neg_flag(alu_neg_flag), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_result_bin(rsp_result_bin), .rsp_carry_bin(rsp_carry_bin),
      .rsp_zero_flag(rsp_zero_flag), .rsp_neg_flag(rsp_neg_flag), .sync_err(sync_err)
   );

   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
      return (a ^ {b[7:0], b[15:8]}) + {13'd0, op};
   endfunction

   // Toy ALU: not reset, so it keeps draining across a scheduler reset.
   logic        v1 = 1'b0, v2 = 1'b0;
   logic [15:0] d1 = '0, d2 = '0;
   logic        drop_arm = 1'b0, force_vout = 1'b0;
   always @(posedge clk) begin
      v1 <= alu_valid_in & !drop_arm;
      d1 <= alu_f(alu_a_bin, alu_b_bin, alu_op);
      v2 <= v1;
      d2 <= d1;
   end
   assign alu_valid_out  = v2 | force_vout;
   assign alu_result_bin = d2;
   assign alu_carry_bin  = d2[1:0] ^ 2'b10;
   assign alu_zero_flag  = (d2 == 16'd0);
   assign alu_neg_flag   = d2[15];

   typedef struct { int due; int id; logic [15:0] res; bit dropped; } exp_t;
   exp_t        q[$];
   bit          pend[N];
   logic [15:0] pa[N], pb[N];
   logic [2:0]  po[N];
   int          rr = N - 1;
   int          cyc = 0;
   int          checks = 0, errors = 0;
   bit          exp_avi = 1'b0;
   logic [15:0] exp_a, exp_b;
   logic [2:0]  exp_op;
   bit          want_drop = 1'b0;
   int          drop_cyc = -1;
   logic [N-1:0] last_rdy;
   logic        last_rsp_v;
   logic [1:0]  last_rsp_id;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic refill(input logic [N-1:0] mask);
      for (int i = 0; i < N; i++)
         if (mask[i] && !pend[i]) begin
            pend[i] = 1'b1;
            pa[i]   = 16'($urandom());
            pb[i]   = 16'($urandom());
            po[i]   = 3'($urandom_range(0, 7));
         end
   endtask

   // One clock cycle: drive, check comb/registered outputs mid-cycle, advance the model.
   task automatic tick();
      int g, j;
      logic [N-1:0] er;
      exp_t e;
      bit ev;
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = pend[i];
         req_a_bin[16*i +: 16] = pa[i];
         req_b_bin[16*i +: 16] = pb[i];
         req_op[3*i +: 3]      = po[i];
      end
      drop_arm = (cyc == drop_cyc);
      #3;
      g = -1;
      if (!rst && !hold)
         for (int k = 1; k <= N; k++) begin
            j = (rr + k) % N;
            if (g < 0 && pend[j]) g = j;
         end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      last_rdy = req_ready; last_rsp_v = rsp_valid; last_rsp_id = rsp_id;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("alu_valid_in", 32'(alu_valid_in), 32'(exp_avi));
      if (exp_avi) begin
         chk("alu_a", 32'(alu_a_bin), 32'(exp_a));
         chk("alu_b", 32'(alu_b_bin), 32'(exp_b));
         chk("alu_op", 32'(alu_op), 32'(exp_op));
      end
      ev = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e  = q.pop_front();
         ev = !e.dropped && !rst;
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
         chk("rsp_id", 32'(rsp_id), 32'(e.id));
         chk("rsp_result", 32'(rsp_result_bin), 32'(e.res));
         chk("rsp_carry", 32'(rsp_carry_bin), 32'(e.res[1:0] ^ 2'b10));
         chk("rsp_zero", 32'(rsp_zero_flag), 32'(e.res == 16'd0));
         chk("rsp_neg", 32'(rsp_neg_flag), 32'(e.res[15]));
      end
      if (rst) begin
         q.delete();
         rr = N - 1;
      end
      exp_avi = (g >= 0);
      if (g >= 0) begin
         rr = g;
         exp_a = pa[g]; exp_b = pb[g]; exp_op = po[g];
         q.push_back('{cyc + 1 + L, g, alu_f(pa[g], pb[g], po[g]), want_drop});
         if (want_drop) begin
            drop_cyc  = cyc + 1;
            want_drop = 1'b0;
         end
         pend[g] = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      hold = 1'b0; req_valid = '0; req_a_bin = '0; req_b_bin = '0; req_op = '0;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; po[i] = '0;
      end
      @(posedge clk);
      #1;
      tick(); tick();
      chk("reset_sync_err", 32'(sync_err), 32'd0);
      rst = 1'b0;

      // Single request from requester 2
      pend[2] = 1'b1; pa[2] = 16'h0001; pb[2] = 16'h0001; po[2] = 3'd0;
      tick(); chk("single_grant", 32'(last_rdy), 32'h4);
      tick(); tick();
      tick(); chk("single_rsp_v", 32'(last_rsp_v), 32'd1);
      chk("single_rsp_id", 32'(last_rsp_id), 32'd2);
      tick();

      // All requesters busy from reset: strict rotation, responses 3 cycles behind
      refill(4'hF);
      rst = 1'b1;
      tick(); chk("ready_in_reset", 32'(last_rdy), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         refill(4'hF);
         tick();
         chk("rotation", 32'(last_rdy), 32'(1 << (k % 4)));
         if (k >= 3) begin
            chk("rotation_rsp_v", 32'(last_rsp_v), 32'd1);
            chk("rotation_rsp_id", 32'(last_rsp_id), 32'((k - 3) % 4));
         end
      end

      // Wrap after grant 3 with only 1 and 3 requesting
      pend[0] = 1'b0; pend[2] = 1'b0;
      refill(4'b1010);
      tick(); chk("wrap_g1", 32'(last_rdy), 32'h2);
      tick(); chk("wrap_g3", 32'(last_rdy), 32'h8);

      // hold blocks new grants only
      refill(4'b0001);
      hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick(); chk("hold_ready", 32'(last_rdy), 32'd0);
      end
      hold = 1'b0;
      tick(); chk("hold_resume", 32'(last_rdy), 32'h1);
      repeat (4) tick();

      // Reset with ops in flight: no responses, draining ALU sets sync_err
      chk("pre_sync_err", 32'(sync_err), 32'd0);
      refill(4'b0011);
      tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (4) tick();
      chk("drain_sync_err", 32'(sync_err), 32'd1);
      force_vout = 1'b1; tick(); force_vout = 1'b0;
      repeat (2) tick();
      chk("sticky_sync_err", 32'(sync_err), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("cleared_sync_err", 32'(sync_err), 32'd0);

      // Dropped ALU valid: lost response, sync_err, later op still routed
      want_drop = 1'b1;
      refill(4'b0100);
      tick();
      refill(4'b0001);
      tick(); tick();
      tick(); chk("drop_no_rsp", 32'(last_rsp_v), 32'd0);
      tick(); chk("post_drop_rsp_v", 32'(last_rsp_v), 32'd1);
      chk("post_drop_rsp_id", 32'(last_rsp_id), 32'd0);
      chk("drop_sync_err", 32'(sync_err), 32'd1);

      // Random traffic with occasional hold
      for (int k = 0; k < 120; k++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1) refill(4'(1 << i));
         hold = ($urandom_range(0, 7) == 0);
         tick();
      end
      hold = 1'b1;
      repeat (5) tick();
      chk("final_sync_err", 32'(sync_err), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
